// File: rtl/vga_capture_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_capture_if
//  Purpose  : Raster input (href/vsync/rgb) and capture result bundle for
//             vga_capture. The master modport is the raster source and the
//             result consumer. The slave modport is the capture block.
//  Revision : 1.0  initial release
// ============================================================================
interface vga_capture_if #(
    parameter int XW = 10,
    parameter int YW = 10
);
    logic          href;
    logic          vsync;
    logic [11:0]   rgb;
    logic          pix_valid;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [11:0]   pix_rgb;
    logic          frame_start;
    logic          line_done;
    logic          frame_done;
    logic          locked;
    logic          err_hlen;
    logic          err_vlen;
    logic [15:0]   frame_cnt;
    logic [15:0]   frame_sum;

    modport master (
        output href, vsync, rgb,
        input  pix_valid, pix_x, pix_y, pix_rgb, frame_start, line_done,
               frame_done, locked, err_hlen, err_vlen, frame_cnt, frame_sum
    );

    modport slave (
        input  href, vsync, rgb,
        output pix_valid, pix_x, pix_y, pix_rgb, frame_start, line_done,
               frame_done, locked, err_hlen, err_vlen, frame_cnt, frame_sum
    );
endinterface
`default_nettype wire

// File: rtl/vga_capture.sv
`default_nettype none
// ============================================================================
//  Module   : vga_capture
//  Purpose  : VGA raster receiver. Recovers pixel coordinates from href/vsync,
//             emits a pixel-valid stream, checks line/frame geometry, reports
//             lock and errors and counts good frames.
//             Optional macro VGA_CAP_CHECKSUM_EN adds a per-frame rgb checksum
//             on frame_sum; without it frame_sum is constant zero.
//  Revision : 1.0  initial release
// ============================================================================
module vga_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int XW       = 10,
    parameter int YW       = 10
) (
    input  wire         clk,
    input  wire         rst,
    vga_capture_if.slave bus
);
    localparam logic [XW-1:0] c_x_max    = '1;
    localparam logic [YW-1:0] c_y_max    = '1;
    localparam logic [31:0]   c_h_active = 32'(H_ACTIVE);
    localparam logic [31:0]   c_v_active = 32'(V_ACTIVE);

    typedef enum logic [1:0] {
        S_WAIT_VS   = 2'd0,
        S_VSYNC     = 2'd1,
        S_LINE_WAIT = 2'd2,
        S_ACTIVE    = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_href_q;
    logic          r_vsync_q;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_pix_valid;
    logic [XW-1:0] r_pix_x;
    logic [YW-1:0] r_pix_y;
    logic [11:0]   r_pix_rgb;
    logic          r_frame_start;
    logic          r_line_done;
    logic          r_frame_done;
    logic          r_locked;
    logic          r_err_hlen;
    logic          r_err_vlen;
    logic [15:0]   r_frame_cnt;

    logic          w_vs_fall;
    logic          w_frame_end;
    logic          w_href_rise;
    logic          w_pix_take;
    logic [XW-1:0] w_pix_x;
    logic [XW-1:0] w_x_inc;
    logic [YW-1:0] w_y_inc;
    logic          w_pix_ok;

    // Edge detection and the pixel decision for the current sample.
    // A vsync fall in WAIT_VS only arms the block; elsewhere it closes a frame.
    // The href-rise cycle already carries pixel 0 of the line.
    always_comb begin
        w_vs_fall   = r_vsync_q & ~bus.vsync;
        w_frame_end = w_vs_fall && (r_state != S_WAIT_VS);
        w_href_rise = ~r_href_q & bus.href;
        w_pix_take  = bus.vsync && (((r_state == S_LINE_WAIT) && w_href_rise) ||
                                    ((r_state == S_ACTIVE) && bus.href));
        w_pix_x     = (r_state == S_LINE_WAIT) ? '0 : r_x;
        w_x_inc     = (w_pix_x == c_x_max) ? w_pix_x : w_pix_x + XW'(1);
        w_y_inc     = (r_y == c_y_max) ? r_y : r_y + YW'(1);
        w_pix_ok    = w_pix_take && (32'(w_pix_x) < c_h_active) &&
                      (32'(r_y) < c_v_active);
    end

    // Raster FSM, coordinate counters and all registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_WAIT_VS;
            r_href_q      <= 1'b0;
            r_vsync_q     <= 1'b1;
            r_x           <= '0;
            r_y           <= '0;
            r_pix_valid   <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_rgb     <= '0;
            r_frame_start <= 1'b0;
            r_line_done   <= 1'b0;
            r_frame_done  <= 1'b0;
            r_locked      <= 1'b0;
            r_err_hlen    <= 1'b0;
            r_err_vlen    <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_href_q      <= bus.href;
            r_vsync_q     <= bus.vsync;
            r_pix_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_done   <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err_hlen    <= 1'b0;
            r_err_vlen    <= 1'b0;

            if (w_pix_ok) begin
                r_pix_valid   <= 1'b1;
                r_pix_x       <= w_pix_x;
                r_pix_y       <= r_y;
                r_pix_rgb     <= bus.rgb;
                r_frame_start <= (w_pix_x == '0) && (r_y == '0);
            end

            if (w_frame_end) begin
                // An open line at the frame boundary is a short line and is not counted.
                r_frame_done <= 1'b1;
                if (r_state == S_ACTIVE) begin
                    r_err_hlen <= 1'b1;
                end
                if (32'(r_y) == c_v_active) begin
                    r_locked    <= 1'b1;
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end else begin
                    r_err_vlen <= 1'b1;
                    r_locked   <= 1'b0;
                end
                r_x     <= '0;
                r_y     <= '0;
                r_state <= S_VSYNC;
            end else begin
                case (r_state)
                    S_WAIT_VS: begin
                        if (w_vs_fall) begin
                            r_state <= S_VSYNC;
                        end
                    end
                    S_VSYNC: begin
                        if (bus.vsync) begin
                            r_state <= S_LINE_WAIT;
                        end
                    end
                    S_LINE_WAIT: begin
                        if (w_pix_take) begin
                            r_x     <= w_x_inc;
                            r_state <= S_ACTIVE;
                        end
                    end
                    S_ACTIVE: begin
                        if (w_pix_take) begin
                            r_x <= w_x_inc;
                        end else if (!bus.href) begin
                            r_line_done <= 1'b1;
                            r_err_hlen  <= (32'(r_x) != c_h_active);
                            r_y         <= w_y_inc;
                            r_x         <= '0;
                            r_state     <= S_LINE_WAIT;
                        end
                    end
                    default: r_state <= S_WAIT_VS;
                endcase
            end
        end
    end

    assign bus.pix_valid   = r_pix_valid;
    assign bus.pix_x       = r_pix_x;
    assign bus.pix_y       = r_pix_y;
    assign bus.pix_rgb     = r_pix_rgb;
    assign bus.frame_start = r_frame_start;
    assign bus.line_done   = r_line_done;
    assign bus.frame_done  = r_frame_done;
    assign bus.locked      = r_locked;
    assign bus.err_hlen    = r_err_hlen;
    assign bus.err_vlen    = r_err_vlen;
    assign bus.frame_cnt   = r_frame_cnt;

`ifdef VGA_CAP_CHECKSUM_EN
    logic [15:0] r_acc;
    logic [15:0] r_frame_sum;

    // Running rgb sum of accepted pixels, published and cleared at each frame close.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc       <= '0;
            r_frame_sum <= '0;
        end else if (w_frame_end) begin
            r_frame_sum <= r_acc;
            r_acc       <= '0;
        end else if (w_pix_ok) begin
            r_acc <= r_acc + {4'b0000, bus.rgb};
        end
    end

    assign bus.frame_sum = r_frame_sum;
`else
    assign bus.frame_sum = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_capture
//  Purpose  : Self-checking bench for vga_capture with a reduced raster
//             (16x8) and randomized pixel data, blanking and sync widths.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_capture;
    localparam int H    = 16;
    localparam int V    = 8;
    localparam int XW   = 5;
    localparam int YW   = 4;
    localparam int XMAX = (1 << XW) - 1;
    localparam int YMAX = (1 << YW) - 1;
`ifdef VGA_CAP_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_capture_if #(.XW(XW), .YW(YW)) bus ();

    vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .XW(XW), .YW(YW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Observed event streams (filled by the monitor) and expected streams (model).
    logic [21:0] obs_pix[$], exp_pix[$];   // {frame_start, y, x, rgb}
    logic        obs_ld[$],  exp_ld[$];    // err_hlen at line_done
    logic [34:0] obs_fd[$],  exp_fd[$];    // {err_hlen, err_vlen, locked, cnt, sum}
    int          stray = 0;

    // Frame-level reference model state.
    bit          m_armed;
    int          m_lines;
    bit          m_partial;
    bit          m_locked;
    logic [15:0] m_cnt;
    logic [15:0] m_sum;

    logic [59:0] all_outs;
    assign all_outs = {bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_rgb, bus.frame_start,
                       bus.line_done, bus.frame_done, bus.locked, bus.err_hlen,
                       bus.err_vlen, bus.frame_cnt, bus.frame_sum};

    // Record DUT events away from the active edge.
    always @(negedge clk) begin
        if (bus.pix_valid) obs_pix.push_back({bus.frame_start, bus.pix_y, bus.pix_x, bus.pix_rgb});
        else if (bus.frame_start) stray++;
        if (bus.line_done) obs_ld.push_back(bus.err_hlen);
        if (bus.frame_done)
            obs_fd.push_back({bus.err_hlen, bus.err_vlen, bus.locked, bus.frame_cnt, bus.frame_sum});
        if (bus.err_hlen && !bus.line_done && !bus.frame_done) stray++;
        if (bus.err_vlen && !bus.frame_done) stray++;
    end

    task automatic drive(input logic h, input logic v, input logic [11:0] c);
        bus.href  = h;
        bus.vsync = v;
        bus.rgb   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_armed = 0; m_lines = 0; m_partial = 0; m_locked = 0; m_cnt = '0; m_sum = '0;
    endtask

    task automatic clear_streams();
        obs_pix.delete(); exp_pix.delete();
        obs_ld.delete();  exp_ld.delete();
        obs_fd.delete();  exp_fd.delete();
    endtask

    // One href burst of len cycles; partial=1 leaves href high for a sync cut.
    task automatic send_line(input int len, input bit partial, input bit const_rgb);
        logic [11:0] c;
        for (int i = 0; i < len; i++) begin
            c = const_rgb ? 12'h00F : 12'($urandom);
            if (m_armed && i < H && m_lines < V) begin
                exp_pix.push_back({(i == 0 && m_lines == 0), YW'(m_lines), XW'(i), c});
                m_sum += {4'b0000, c};
            end
            drive(1'b1, 1'b1, c);
        end
        if (partial) begin
            m_partial = m_armed;
        end else begin
            if (m_armed) begin
                exp_ld.push_back(((len > XMAX) ? XMAX : len) != H);
                m_lines = (m_lines < YMAX) ? m_lines + 1 : YMAX;
            end
            repeat ($urandom_range(2, 4)) drive(1'b0, 1'b1, 12'($urandom));
        end
    endtask

    task automatic send_frame(input int nlines, input int bad_idx, input int bad_len,
                              input bit const_rgb);
        for (int l = 0; l < nlines; l++)
            send_line((l == bad_idx) ? bad_len : H, 1'b0, const_rgb);
    endtask

    // Sync pulse: closes the current frame (if armed); href noise while low.
    task automatic vs_pulse();
        bit good;
        if (m_armed) begin
            good = (m_lines == V);
            if (good) begin
                m_locked = 1;
                m_cnt    = m_cnt + 16'd1;
            end else begin
                m_locked = 0;
            end
            exp_fd.push_back({m_partial, !good, m_locked, m_cnt, CSUM ? m_sum : 16'h0000});
        end
        m_armed = 1; m_lines = 0; m_partial = 0; m_sum = '0;
        drive(bus.href, 1'b0, 12'($urandom));
        repeat ($urandom_range(1, 3)) drive(1'($urandom), 1'b0, 12'($urandom));
        repeat ($urandom_range(2, 3)) drive(1'b0, 1'b1, 12'($urandom));
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.href  = 1'($urandom);
            bus.vsync = 1'($urandom);
            bus.rgb   = 12'($urandom);
            #1;
            n_checks++;
            if (all_outs !== '0) $display("FAIL reset_outputs[%0d]: got %h expected 0", i, all_outs);
            else n_pass++;
        end
        bus.href = 1'b0; bus.vsync = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        clear_streams();
    endtask

    task automatic test_clean_frames();
        int s0 = stray;
        logic [21:0] e;
        clear_streams();
        vs_pulse();
        for (int f = 0; f < 3; f++) begin
            send_frame(V, -1, 0, 1'b0);
            vs_pulse();
        end
        @(negedge clk); #1;
        n_checks++;
        if (obs_pix.size() != exp_pix.size()) $display("FAIL clean pix_count: got %0d expected %0d", obs_pix.size(), exp_pix.size());
        else n_pass++;
        foreach (exp_pix[i]) if (i < obs_pix.size()) begin
            n_checks++;
            if (obs_pix[i] !== exp_pix[i]) $display("FAIL clean pix[%0d]: got %h expected %h", i, obs_pix[i], exp_pix[i]);
            else n_pass++;
        end
        if (obs_pix.size() >= H * V) begin
            e = obs_pix[H * V - 1];
            n_checks++;
            if (e[20:12] !== {YW'(V - 1), XW'(H - 1)}) $display("FAIL clean last_pixel: got y=%0d x=%0d expected y=%0d x=%0d", e[20:17], e[16:12], V - 1, H - 1);
            else n_pass++;
        end
        n_checks++;
        if (obs_ld.size() != exp_ld.size() || obs_ld != exp_ld) $display("FAIL clean line_done: got %0d events expected %0d", obs_ld.size(), exp_ld.size());
        else n_pass++;
        n_checks++;
        if (obs_fd.size() != exp_fd.size()) $display("FAIL clean frame_done_count: got %0d expected %0d", obs_fd.size(), exp_fd.size());
        else n_pass++;
        foreach (exp_fd[i]) if (i < obs_fd.size()) begin
            n_checks++;
            if (obs_fd[i] !== exp_fd[i]) $display("FAIL clean frame[%0d]: got %h expected %h", i, obs_fd[i], exp_fd[i]);
            else n_pass++;
        end
        n_checks++;
        if (stray !== s0) $display("FAIL clean stray_pulses: got %0d expected %0d", stray, s0);
        else n_pass++;
    endtask

    task automatic test_line_errors();
        int s0 = stray;
        clear_streams();
        send_frame(3, 2, H - 1, 1'b0);
        n_checks++;
        if (bus.locked !== 1'b1) $display("FAIL lineerr locked_after_short_line: got %b expected 1", bus.locked);
        else n_pass++;
        send_line(40, 1'b0, 1'b0);
        send_frame(V - 4, -1, 0, 1'b0);
        vs_pulse();
        send_frame(V, -1, 0, 1'b0);
        send_line(5, 1'b1, 1'b0);
        vs_pulse();
        @(negedge clk); #1;
        n_checks++;
        if (obs_pix.size() != exp_pix.size()) $display("FAIL lineerr pix_count: got %0d expected %0d", obs_pix.size(), exp_pix.size());
        else n_pass++;
        foreach (exp_pix[i]) if (i < obs_pix.size()) begin
            n_checks++;
            if (obs_pix[i] !== exp_pix[i]) $display("FAIL lineerr pix[%0d]: got %h expected %h", i, obs_pix[i], exp_pix[i]);
            else n_pass++;
        end
        n_checks++;
        if (obs_ld.size() != exp_ld.size()) $display("FAIL lineerr line_done_count: got %0d expected %0d", obs_ld.size(), exp_ld.size());
        else n_pass++;
        foreach (exp_ld[i]) if (i < obs_ld.size()) begin
            n_checks++;
            if (obs_ld[i] !== exp_ld[i]) $display("FAIL lineerr err_hlen[%0d]: got %b expected %b", i, obs_ld[i], exp_ld[i]);
            else n_pass++;
        end
        n_checks++;
        if (obs_fd.size() != exp_fd.size()) $display("FAIL lineerr frame_done_count: got %0d expected %0d", obs_fd.size(), exp_fd.size());
        else n_pass++;
        foreach (exp_fd[i]) if (i < obs_fd.size()) begin
            n_checks++;
            if (obs_fd[i] !== exp_fd[i]) $display("FAIL lineerr frame[%0d]: got %h expected %h", i, obs_fd[i], exp_fd[i]);
            else n_pass++;
        end
        n_checks++;
        if (stray !== s0) $display("FAIL lineerr stray_pulses: got %0d expected %0d", stray, s0);
        else n_pass++;
    endtask

    task automatic test_frame_errors();
        int s0 = stray;
        logic [15:0] cnt0;
        clear_streams();
        cnt0 = m_cnt;
        send_frame(V - 1, -1, 0, 1'b0);
        vs_pulse();
        n_checks++;
        if ({bus.locked, bus.frame_cnt} !== {1'b0, cnt0}) $display("FAIL frameerr short_frame: got locked=%b cnt=%0d expected locked=0 cnt=%0d", bus.locked, bus.frame_cnt, cnt0);
        else n_pass++;
        send_frame(V + 1, -1, 0, 1'b0);
        vs_pulse();
        send_frame(V, -1, 0, 1'b0);
        vs_pulse();
        @(negedge clk); #1;
        n_checks++;
        if ({bus.locked, bus.frame_cnt} !== {1'b1, cnt0 + 16'd1}) $display("FAIL frameerr relock: got locked=%b cnt=%0d expected locked=1 cnt=%0d", bus.locked, bus.frame_cnt, cnt0 + 16'd1);
        else n_pass++;
        n_checks++;
        if (obs_pix.size() != exp_pix.size() || obs_pix != exp_pix) $display("FAIL frameerr pixels: got %0d pixels expected %0d", obs_pix.size(), exp_pix.size());
        else n_pass++;
        n_checks++;
        if (obs_ld.size() != exp_ld.size() || obs_ld != exp_ld) $display("FAIL frameerr line_done: got %0d events expected %0d", obs_ld.size(), exp_ld.size());
        else n_pass++;
        n_checks++;
        if (obs_fd.size() != exp_fd.size()) $display("FAIL frameerr frame_done_count: got %0d expected %0d", obs_fd.size(), exp_fd.size());
        else n_pass++;
        foreach (exp_fd[i]) if (i < obs_fd.size()) begin
            n_checks++;
            if (obs_fd[i] !== exp_fd[i]) $display("FAIL frameerr frame[%0d]: got %h expected %h", i, obs_fd[i], exp_fd[i]);
            else n_pass++;
        end
        n_checks++;
        if (stray !== s0) $display("FAIL frameerr stray_pulses: got %0d expected %0d", stray, s0);
        else n_pass++;
    endtask

    task automatic test_midframe_reset();
        int s0 = stray;
        clear_streams();
        send_frame(2, -1, 0, 1'b0);
        send_line(H / 2, 1'b1, 1'b0);
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (all_outs !== '0) $display("FAIL midreset immediate_clear: got %h expected 0", all_outs);
        else n_pass++;
        model_reset();
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 12'($urandom));
        drive(1'b1, 1'b1, 12'($urandom));
        rst = 1'b1;
        repeat (3) drive(1'b1, 1'b1, 12'($urandom));
        drive(1'b0, 1'b1, 12'($urandom));
        send_frame(3, -1, 0, 1'b0);
        n_checks++;
        if (obs_pix.size() != exp_pix.size()) $display("FAIL midreset no_pixels_before_sync: got %0d expected %0d", obs_pix.size(), exp_pix.size());
        else n_pass++;
        vs_pulse();
        send_frame(V, -1, 0, 1'b0);
        vs_pulse();
        @(negedge clk); #1;
        n_checks++;
        if (obs_pix.size() != exp_pix.size() || obs_pix != exp_pix) $display("FAIL midreset pixels: got %0d pixels expected %0d", obs_pix.size(), exp_pix.size());
        else n_pass++;
        n_checks++;
        if (obs_ld.size() != exp_ld.size() || obs_ld != exp_ld) $display("FAIL midreset line_done: got %0d events expected %0d", obs_ld.size(), exp_ld.size());
        else n_pass++;
        n_checks++;
        if (obs_fd.size() != 1) $display("FAIL midreset frame_done_count: got %0d expected 1", obs_fd.size());
        else n_pass++;
        if (obs_fd.size() >= 1) begin
            n_checks++;
            if (obs_fd[0] !== exp_fd[0]) $display("FAIL midreset frame: got %h expected %h", obs_fd[0], exp_fd[0]);
            else n_pass++;
        end
        n_checks++;
        if (stray !== s0) $display("FAIL midreset stray_pulses: got %0d expected %0d", stray, s0);
        else n_pass++;
    endtask

    task automatic test_checksum();
        logic [15:0] want;
        want = CSUM ? 16'(H * V * 15) : 16'h0000;
        clear_streams();
        send_frame(V, -1, 0, 1'b1);
        vs_pulse();
        @(negedge clk); #1;
        n_checks++;
        if (bus.frame_sum !== want) $display("FAIL checksum frame_sum: got %h expected %h", bus.frame_sum, want);
        else n_pass++;
        n_checks++;
        if (obs_fd.size() != 1) $display("FAIL checksum frame_done_count: got %0d expected 1", obs_fd.size());
        else n_pass++;
        if (obs_fd.size() >= 1 && exp_fd.size() >= 1) begin
            n_checks++;
            if (obs_fd[0] !== exp_fd[0]) $display("FAIL checksum frame: got %h expected %h", obs_fd[0], exp_fd[0]);
            else n_pass++;
        end
    endtask

    initial begin
        bus.href  = 1'b0;
        bus.vsync = 1'b1;
        bus.rgb   = '0;
        rst       = 1'b0;
        test_reset();
        test_clean_frames();
        test_line_errors();
        test_frame_errors();
        test_midframe_reset();
        test_checksum();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
